// File: rtl/stride_loop_counter.sv
// stride_loop_counter
//   Programmable strided loop counter for the vector datapath. Counts from a
//   latched start value towards a latched inclusive limit in steps of a
//   latched stride, either up or down. At the end of the range it either
//   reloads start and pulses wrap (SAT_MODE=0) or parks at limit in DONE
//   (SAT_MODE=1).
//
// Ports
//   clk       clock, all state updates on posedge
//   rst       synchronous reset, active-high
//   load      latch start/step/limit/dir, out <= start, enter RUN
//   en        advance one step (RUN only)
//   dir       0: count up, limit is upper bound; 1: count down, limit is lower bound
//   start     first value of the range
//   step      stride
//   limit     inclusive end of range
//   out       current count (registered)
//   wrap      one-cycle registered pulse, high while out has just reloaded start
//   done      high in DONE (SAT_MODE=1 only)
//   busy      high in RUN
//   at_limit  out equals latched limit (register-only logic)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, nothing loaded, en ignored
// RUN   | counting, en advances by one stride
// DONE  | saturated at limit (SAT_MODE=1), en ignored until load/rst

module stride_loop_counter #(
    parameter int N        = 32,
    parameter int SAT_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic         dir,
    input  logic [N-1:0] start,
    input  logic [N-1:0] step,
    input  logic [N-1:0] limit,
    output logic [N-1:0] out,
    output logic         wrap,
    output logic         done,
    output logic         busy,
    output logic         at_limit
);

    localparam bit SAT = (SAT_MODE != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] out_q, out_d;
    logic         wrap_q, wrap_d;
    logic [N-1:0] start_q, step_q, limit_q;
    logic         dir_q;

    logic [N:0]   sum, diff;
    logic [N-1:0] nxt;
    logic         term;

    // Candidate next value on N+1 bits so carry/borrow marks overshoot
    // past the representable range as terminal.
    always_comb begin
        sum  = {1'b0, out_q} + {1'b0, step_q};
        diff = {1'b0, out_q} - {1'b0, step_q};
        if (dir_q) begin
            nxt  = diff[N-1:0];
            term = diff[N] | (diff[N-1:0] < limit_q);
        end else begin
            nxt  = sum[N-1:0];
            term = sum[N] | (sum[N-1:0] > limit_q);
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        wrap_d  = 1'b0;
        if (load) begin
            out_d   = start;
            state_d = S_RUN;
        end else if (state_q == S_RUN && en) begin
            if (!term) begin
                out_d = nxt;
            end else if (!SAT) begin
                out_d  = start_q;
                wrap_d = 1'b1;
            end else begin
                out_d   = limit_q;
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            wrap_q  <= 1'b0;
            start_q <= '0;
            step_q  <= '0;
            limit_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
            if (load) begin
                start_q <= start;
                step_q  <= step;
                limit_q <= limit;
                dir_q   <= dir;
            end
        end
    end

    assign out      = out_q;
    assign wrap     = wrap_q;
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign at_limit = (out_q == limit_q);

endmodule

// File: tb/tb_stride_loop_counter.sv
// Bench for stride_loop_counter: one wrap-mode and one saturate-mode
// instance (N=8) share the same inputs; expectations come from directed
// constants and from an integer-arithmetic reference model.
module tb_stride_loop_counter;

    logic       clk = 1'b0;
    logic       rst, load, en, dir;
    logic [7:0] start, step, limit;
    logic [7:0] out0, out1;
    logic       wrap0, wrap1, done0, done1, busy0, busy1, atl0, atl1;

    int checks   = 0;
    int failures = 0;

    // Reference model: latched range shared, per-mode count/flags.
    int m_start, m_step, m_limit;
    bit m_dir;
    int m_out[2];
    bit m_wrap[2], m_busy[2], m_done[2];

    always #5 clk = ~clk;

    stride_loop_counter #(.N(8), .SAT_MODE(0)) dut_wrap (
        .clk(clk), .rst(rst), .load(load), .en(en), .dir(dir),
        .start(start), .step(step), .limit(limit),
        .out(out0), .wrap(wrap0), .done(done0), .busy(busy0), .at_limit(atl0)
    );

    stride_loop_counter #(.N(8), .SAT_MODE(1)) dut_sat (
        .clk(clk), .rst(rst), .load(load), .en(en), .dir(dir),
        .start(start), .step(step), .limit(limit),
        .out(out1), .wrap(wrap1), .done(done1), .busy(busy1), .at_limit(atl1)
    );

    task automatic model_edge();
        if (rst) begin
            m_start = 0; m_step = 0; m_limit = 0; m_dir = 0;
            for (int m = 0; m < 2; m++) begin
                m_out[m] = 0; m_wrap[m] = 0; m_busy[m] = 0; m_done[m] = 0;
            end
        end else if (load) begin
            m_start = start; m_step = step; m_limit = limit; m_dir = dir;
            for (int m = 0; m < 2; m++) begin
                m_out[m] = m_start; m_wrap[m] = 0; m_busy[m] = 1; m_done[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int  nv;
                bit  past;
                m_wrap[m] = 0;
                if (m_busy[m] && en) begin
                    nv   = m_dir ? m_out[m] - m_step : m_out[m] + m_step;
                    past = m_dir ? (nv < m_limit) : (nv > m_limit);
                    if (!past) m_out[m] = nv;
                    else if (m == 0) begin
                        m_out[m] = m_start; m_wrap[m] = 1;
                    end else begin
                        m_out[m] = m_limit; m_busy[m] = 0; m_done[m] = 1;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic cycle(input bit r, input bit ld, input bit e, input bit d,
                         input logic [7:0] s, input logic [7:0] st, input logic [7:0] l);
        rst = r; load = ld; en = e; dir = d; start = s; step = st; limit = l;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 1, 0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0, 8'd3, 8'd1, 8'd9);
            checks++;
            if (out0 !== 8'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || wrap0 !== 1'b0 ||
                out1 !== 8'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || wrap1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: out=%0d/%0d busy=%b/%b done=%b/%b wrap=%b/%b, required all 0",
                         i, out0, out1, busy0, busy1, done0, done1, wrap0, wrap1);
            end
        end
    endtask

    task automatic test_wrap_and_sat();
        int e0[5] = '{2, 5, 8, 2, 5};
        bit w0[5] = '{0, 0, 0, 1, 0};
        int e1[5] = '{2, 5, 8, 10, 10};
        bit d1[5] = '{0, 0, 0, 1, 1};
        cycle(1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, i == 0, 1, 0, 8'd2, 8'd3, 8'd10);
            checks++;
            if (out0 !== e0[i][7:0] || wrap0 !== w0[i]) begin
                failures++;
                $display("FAIL wrap_seq[%0d]: out=%0d wrap=%b, required out=%0d wrap=%b",
                         i, out0, wrap0, e0[i], w0[i]);
            end
            checks++;
            if (out1 !== e1[i][7:0] || done1 !== d1[i] || busy1 !== !d1[i] || wrap1 !== 1'b0) begin
                failures++;
                $display("FAIL sat_seq[%0d]: out=%0d done=%b busy=%b wrap=%b, required out=%0d done=%b busy=%b wrap=0",
                         i, out1, done1, busy1, wrap1, e1[i], d1[i], !d1[i]);
            end
        end
        checks++;
        if (atl1 !== 1'b1) begin
            failures++;
            $display("FAIL sat_at_limit: got %b required 1", atl1);
        end
    endtask

    task automatic test_carry();
        cycle(0, 1, 0, 0, 8'd250, 8'd10, 8'd255);
        cycle(0, 0, 1, 0, 8'd0, 8'd0, 8'd0);
        checks++;
        if (out0 !== 8'd250 || wrap0 !== 1'b1) begin
            failures++;
            $display("FAIL carry_wrap: out=%0d wrap=%b, required out=250 wrap=1", out0, wrap0);
        end
        checks++;
        if (out1 !== 8'd255 || done1 !== 1'b1) begin
            failures++;
            $display("FAIL carry_sat: out=%0d done=%b, required out=255 done=1", out1, done1);
        end
    endtask

    task automatic test_borrow();
        int e0[4] = '{20, 13, 6, 20};
        int e1[4] = '{20, 13, 6, 5};
        for (int i = 0; i < 4; i++) begin
            cycle(0, i == 0, i != 0, 1, 8'd20, 8'd7, 8'd5);
            checks++;
            if (out0 !== e0[i][7:0] || wrap0 !== (i == 3) || out1 !== e1[i][7:0] || done1 !== (i == 3)) begin
                failures++;
                $display("FAIL borrow[%0d]: out=%0d/%0d wrap=%b done=%b, required out=%0d/%0d wrap=%b done=%b",
                         i, out0, out1, wrap0, done1, e0[i], e1[i], i == 3, i == 3);
            end
        end
    endtask

    task automatic test_load_with_en();
        cycle(0, 1, 0, 0, 8'd2, 8'd3, 8'd10);
        cycle(0, 0, 1, 0, 8'd0, 8'd0, 8'd0);
        cycle(0, 1, 1, 0, 8'd7, 8'd4, 8'd30);
        checks++;
        if (out0 !== 8'd7 || wrap0 !== 1'b0 || out1 !== 8'd7 || busy1 !== 1'b1 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL load_en: out=%0d/%0d wrap=%b busy1=%b done1=%b, required out=7 wrap=0 busy=1 done=0",
                     out0, out1, wrap0, busy1, done1);
        end
        cycle(0, 0, 1, 0, 8'd0, 8'd0, 8'd0);
        checks++;
        if (out0 !== 8'd11 || out1 !== 8'd11) begin
            failures++;
            $display("FAIL load_en_next: out=%0d/%0d, required 11", out0, out1);
        end
    endtask

    task automatic test_rst_mid();
        cycle(0, 1, 0, 0, 8'd40, 8'd1, 8'd90);
        cycle(0, 0, 1, 0, 8'd0, 8'd0, 8'd0);
        cycle(1, 1, 1, 0, 8'd60, 8'd2, 8'd70);
        checks++;
        if (out0 !== 8'd0 || busy0 !== 1'b0 || out1 !== 8'd0 || busy1 !== 1'b0 || wrap0 !== 1'b0) begin
            failures++;
            $display("FAIL rst_load: out=%0d/%0d busy=%b/%b wrap=%b, required 0",
                     out0, out1, busy0, busy1, wrap0);
        end
        cycle(0, 0, 1, 0, 8'd0, 8'd0, 8'd0);
        checks++;
        if (out0 !== 8'd0 || busy0 !== 1'b0 || busy1 !== 1'b0 || atl0 !== 1'b1) begin
            failures++;
            $display("FAIL rst_idle: out=%0d busy=%b/%b at_limit=%b, required out=0 busy=0 at_limit=1",
                     out0, busy0, busy1, atl0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit         r, ld, e, d;
            logic [7:0] s, st, l;
            r  = ($urandom_range(0, 99) < 2);
            ld = ($urandom_range(0, 99) < 8);
            e  = ($urandom_range(0, 99) < 75);
            d  = $urandom_range(0, 1);
            s  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            l  = 8'($urandom_range(0, 255));
            cycle(r, ld, e, d, s, st, l);
            for (int m = 0; m < 2; m++) begin
                logic [7:0] o;
                logic       w, dn, b, a;
                o  = m ? out1 : out0;
                w  = m ? wrap1 : wrap0;
                dn = m ? done1 : done0;
                b  = m ? busy1 : busy0;
                a  = m ? atl1 : atl0;
                checks++;
                if (o !== m_out[m][7:0] || w !== m_wrap[m] || dn !== m_done[m] || b !== m_busy[m] ||
                    a !== (m_out[m] == m_limit)) begin
                    failures++;
                    $display("FAIL random[%0d] mode%0d: out=%0d wrap=%b done=%b busy=%b atl=%b, required out=%0d wrap=%b done=%b busy=%b atl=%b",
                             i, m, o, w, dn, b, a, m_out[m], m_wrap[m], m_done[m], m_busy[m],
                             m_out[m] == m_limit);
                end
            end
        end
    endtask

    initial begin
        rst = 1; load = 0; en = 0; dir = 0; start = 0; step = 0; limit = 0;
        test_reset();
        test_wrap_and_sat();
        test_carry();
        test_borrow();
        test_load_with_en();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
